vga_text_ctrl: RTL and testbench
================================

Name: vga_text_ctrl

Overview:
- Text-mode controller between the PS/2 keyboard decoder and the 640x480 VGA display driver.
- Keeps an 80x30 character cursor and turns ASCII keystrokes into writes to a single-port character RAM (8x16 glyph cells).
- Shares that RAM port between display reads and keystroke/clear writes. Display reads win on pixel-tick cycles.
- Its character code output feeds the font ROM / pixel generator.

Parameters:
COLS, 80, characters per row
ROWS, 30, character rows
ADDR_W, 12, character RAM address width (COLS*ROWS <= 2**ADDR_W)
BLINK_FRAMES, 30, frames per cursor blink half-period (optional feature only)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous reset, active-high
p_tick  in  1  pixel tick from display driver, one clk in four
data_ena  in  1  display-area flag from display driver
x_pos  in  10  current pixel column
y_pos  in  10  current pixel row
key_valid  in  1  ASCII byte available
key_ascii  in  8  ASCII byte
key_ready  out  1  byte accepted when key_valid && key_ready
mem_addr  out  ADDR_W  character RAM address
mem_we  out  1  character RAM write enable
mem_wdata  out  8  character RAM write data
mem_rdata  in  8  character RAM synchronous read data, valid the clk after the address
disp_char  out  8  character code for the current display cell
cursor_x  out  7  cursor column
cursor_y  out  5  cursor row
busy  out  1  high while any write or clear is pending
cursor_hit  out  1  current cell is the cursor cell and blink is in its on phase

Behaviour:
- Reset values: cursor_x=0, cursor_y=0, key_ready=0, disp_char=0x00, cursor_hit=0, busy=1. State is CLR_ALL with the clear counter at 0.
- Port arbitration is combinational:
  - p_tick=1: mem_addr = display address, mem_we=0. This holds unconditionally.
  - p_tick=0 with a write pending: mem_addr/mem_wdata = write address/data, mem_we=1. The write is granted that cycle.
  - Otherwise: mem_we=0.
- Display address = (y_pos>>4)*COLS + (x_pos>>3) when data_ena=1, else 0.
- disp_char is loaded from mem_rdata on the clk after a p_tick cycle and holds otherwise.
- Cell address = cursor_y*COLS + cursor_x.
- FSM states: IDLE, WR_CHAR, BKSP, CLR_ROW, CLR_ALL.
- IDLE: key_ready=1, busy=0. On accept, the byte is latched and decoded:
  - 0x20-0x7E: go to WR_CHAR with data = byte, address = cursor cell.
  - 0x0D: col=0; row = row+1, or 0 if row==ROWS-1. Go to CLR_ROW.
  - 0x08:
    - col>0: col-1, go to BKSP.
    - col=0 and row>0: col=COLS-1, row-1, go to BKSP.
    - At (0,0): no write, stay IDLE.
  - 0x1B: cursor to (0,0), go to CLR_ALL.
  - Any other byte: consumed, no action.
- key_ready=0 and busy=1 in every state other than IDLE.
- WR_CHAR: on the grant, advance the cursor.
  - col<COLS-1: col+1, return to IDLE.
  - Else: col=0, row+1 (wrapping ROWS-1 to 0), go to CLR_ROW.
- BKSP: writes 0x20 at the (already moved) cursor cell; returns to IDLE on the grant.
- CLR_ROW: writes 0x20 to addresses row*COLS .. row*COLS+COLS-1. The counter advances only on grant; IDLE after the last write.
- CLR_ALL: writes 0x20 to addresses 0 .. COLS*ROWS-1. The counter advances only on grant; IDLE after the last write.
- No write is ever issued on a p_tick cycle. No write is issued to an address >= COLS*ROWS.
- Write latency: a printable byte accepted in cycle T is written in the first p_tick=0 cycle at or after T+1.
- rst asserted mid-operation aborts the current write/clear immediately and returns to the reset values. The full clear is then rerun.
- key_valid while key_ready=0 is ignored; the source must hold the byte.

Optional Feature:
- Macro CURSOR_BLINK_EN.
- Defined:
  - A frame counter advances when p_tick && x_pos==0 && y_pos==0.
  - A blink phase bit toggles every BLINK_FRAMES frames. The phase resets to on.
  - cursor_hit is registered with the same timing as disp_char. It is set when data_ena && display cell == cursor cell && phase on.
- Not defined: cursor_hit tied to 0, and no counter logic is built.

Test Plan:
- Reset released with p_tick running -> exactly 2400 writes of 0x20, addresses 0..2399 in order, none on p_tick cycles; then key_ready=1, busy=0, cursor (0,0).
- 'A' (0x41) at (0,0) -> one write, addr 0, data 0x41; cursor (1,0); key_ready back to 1.
- Cursor (79,0), send 0x42 -> write addr 79 = 0x42, then 80 writes of 0x20 at addr 80..159; cursor (0,1).
- Backspace at (0,1) -> write 0x20 at addr 79, cursor (79,0). Backspace at (0,0) -> no write, cursor unchanged.
- Enter at (5,29) -> cursor (0,0), 80 writes of 0x20 at addr 0..79. Then ESC -> full 2400-write clear; rst pulsed mid-clear -> the clear restarts from addr 0.
- Write pending, p_tick=1, x=17, y=35, data_ena=1 -> mem_addr=162, mem_we=0; mem_rdata=0x5A -> disp_char=0x5A the next clk.

Source files
------------

// File: rtl/vga_text_ctrl.sv
// Text-mode controller: 80x30 cursor, keystroke/clear writes and display reads sharing one char-RAM port.
// Optional cursor blink is built when CURSOR_BLINK_EN is defined; otherwise cursor_hit_o is tied low.
module vga_text_ctrl #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int ADDR_W       = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p_tick_i,
  input  logic              data_ena_i,
  input  logic [9:0]        x_pos_i,
  input  logic [9:0]        y_pos_i,
  input  logic              key_valid_i,
  input  logic [7:0]        key_ascii_i,
  output logic              key_ready_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic [7:0]        disp_char_o,
  output logic [6:0]        cursor_x_o,
  output logic [4:0]        cursor_y_o,
  output logic              busy_o,
  output logic              cursor_hit_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_CHAR = 3'd1,
    BKSP    = 3'd2,
    CLR_ROW = 3'd3,
    CLR_ALL = 3'd4
  } state_e;

  localparam logic [6:0]        LAST_COL   = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW   = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_COL_A = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(COLS * ROWS - 1);

  state_e            state_q, state_d;
  logic [6:0]        cur_x_q, cur_x_d;
  logic [4:0]        cur_y_q, cur_y_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              key_ready_q, busy_q;
  logic              p_tick_q;
  logic [7:0]        disp_char_q;

  logic [ADDR_W-1:0] cell_addr_s, row_base_s, disp_addr_s, wr_addr_s;
  logic [7:0]        wr_data_s;
  logic              pend_s, grant_s;

  assign cell_addr_s = ADDR_W'(cur_y_q) * COLS_A + ADDR_W'(cur_x_q);
  assign row_base_s  = ADDR_W'(cur_y_q) * COLS_A;
  assign pend_s      = (state_q != IDLE);
  assign grant_s     = pend_s && !p_tick_i;

  // Display cell address from the scan position
  always_comb begin
    disp_addr_s = '0;
    if (data_ena_i) begin
      disp_addr_s = ADDR_W'(y_pos_i[9:4]) * COLS_A + ADDR_W'(x_pos_i[9:3]);
    end else begin
      disp_addr_s = '0;
    end
  end

  // Write address/data for the pending operation
  always_comb begin
    wr_addr_s = cell_addr_s;
    wr_data_s = 8'h20;
    case (state_q)
      WR_CHAR: begin wr_addr_s = cell_addr_s;         wr_data_s = data_q; end
      BKSP:    begin wr_addr_s = cell_addr_s;         wr_data_s = 8'h20;  end
      CLR_ROW: begin wr_addr_s = row_base_s + cnt_q;  wr_data_s = 8'h20;  end
      CLR_ALL: begin wr_addr_s = cnt_q;               wr_data_s = 8'h20;  end
      default: begin wr_addr_s = cell_addr_s;         wr_data_s = 8'h20;  end
    endcase
  end

  // RAM port arbitration: display reads own every p_tick cycle
  always_comb begin
    mem_addr_o  = disp_addr_s;
    mem_we_o    = 1'b0;
    mem_wdata_o = wr_data_s;
    if (p_tick_i) begin
      mem_addr_o = disp_addr_s;
      mem_we_o   = 1'b0;
    end else if (pend_s) begin
      mem_addr_o = wr_addr_s;
      mem_we_o   = 1'b1;
    end else begin
      mem_we_o   = 1'b0;
    end
  end

  // Next-state, cursor and clear-counter logic
  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (key_valid_i) begin
          data_d = key_ascii_i;
          if (key_ascii_i >= 8'h20 && key_ascii_i <= 8'h7E) begin
            state_d = WR_CHAR;
          end else if (key_ascii_i == 8'h0D) begin
            cur_x_d = 7'd0;
            cur_y_d = (cur_y_q == LAST_ROW) ? 5'd0 : cur_y_q + 5'd1;
            cnt_d   = '0;
            state_d = CLR_ROW;
          end else if (key_ascii_i == 8'h08) begin
            if (cur_x_q != 7'd0) begin
              cur_x_d = cur_x_q - 7'd1;
              state_d = BKSP;
            end else if (cur_y_q != 5'd0) begin
              cur_x_d = LAST_COL;
              cur_y_d = cur_y_q - 5'd1;
              state_d = BKSP;
            end else begin
              state_d = IDLE;
            end
          end else if (key_ascii_i == 8'h1B) begin
            cur_x_d = 7'd0;
            cur_y_d = 5'd0;
            cnt_d   = '0;
            state_d = CLR_ALL;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR_CHAR: begin
        if (grant_s) begin
          if (cur_x_q != LAST_COL) begin
            cur_x_d = cur_x_q + 7'd1;
            state_d = IDLE;
          end else begin
            cur_x_d = 7'd0;
            cur_y_d = (cur_y_q == LAST_ROW) ? 5'd0 : cur_y_q + 5'd1;
            cnt_d   = '0;
            state_d = CLR_ROW;
          end
        end else begin
          state_d = WR_CHAR;
        end
      end
      BKSP: begin
        if (grant_s) begin
          state_d = IDLE;
        end else begin
          state_d = BKSP;
        end
      end
      CLR_ROW: begin
        if (grant_s) begin
          if (cnt_q == LAST_COL_A) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = CLR_ROW;
        end
      end
      CLR_ALL: begin
        if (grant_s) begin
          if (cnt_q == LAST_CELL) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = CLR_ALL;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = CLR_ALL;
      end
    endcase
  end

  // State, cursor and registered handshake/status outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= CLR_ALL;
      cur_x_q     <= 7'd0;
      cur_y_q     <= 5'd0;
      data_q      <= 8'h00;
      cnt_q       <= '0;
      key_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      p_tick_q    <= 1'b0;
      disp_char_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      key_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      p_tick_q    <= p_tick_i;
      disp_char_q <= p_tick_q ? mem_rdata_i : disp_char_q;
    end
  end

`ifdef CURSOR_BLINK_EN
  logic [15:0] frame_q;
  logic        phase_q, hit_pipe_q, hit_q;

  // Frame counter, blink phase and two-stage cursor-hit pipeline aligned with disp_char
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_q    <= 16'd0;
      phase_q    <= 1'b1;
      hit_pipe_q <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      if (p_tick_i && x_pos_i == 10'd0 && y_pos_i == 10'd0) begin
        if (frame_q == 16'(BLINK_FRAMES - 1)) begin
          frame_q <= 16'd0;
          phase_q <= ~phase_q;
        end else begin
          frame_q <= frame_q + 16'd1;
        end
      end
      if (p_tick_i) begin
        hit_pipe_q <= data_ena_i && (disp_addr_s == cell_addr_s) && phase_q;
      end
      if (p_tick_q) begin
        hit_q <= hit_pipe_q;
      end
    end
  end

  assign cursor_hit_o = hit_q;
`else
  logic unused_s;
  assign unused_s     = ^{x_pos_i[2:0], y_pos_i[3:0], 16'(BLINK_FRAMES)};
  assign cursor_hit_o = 1'b0;
`endif

  assign key_ready_o = key_ready_q;
  assign busy_o      = busy_q;
  assign disp_char_o = disp_char_q;
  assign cursor_x_o  = cur_x_q;
  assign cursor_y_o  = cur_y_q;

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Directed bench for vga_text_ctrl: cursor/RAM model feeds an expected-write queue checked on every write.
module tb_vga_text_ctrl;

  logic        clk = 1'b0;
  logic        rst, p_tick, data_ena, key_valid;
  logic [9:0]  x_pos, y_pos;
  logic [7:0]  key_ascii;
  logic        key_ready, mem_we, busy, cursor_hit;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata, disp_char, ram_rd_q;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        tick_auto, force_rd;
  logic [7:0]  ram [0:4095];

  logic [19:0] exp_q [$];
  int          n_pass = 0, n_total = 0, n_fail = 0, wr_cnt = 0;
  int          cx = 0, cy = 0;

  vga_text_ctrl dut (
    .clk_i(clk), .rst_i(rst), .p_tick_i(p_tick), .data_ena_i(data_ena),
    .x_pos_i(x_pos), .y_pos_i(y_pos), .key_valid_i(key_valid), .key_ascii_i(key_ascii),
    .key_ready_o(key_ready), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .disp_char_o(disp_char),
    .cursor_x_o(cursor_x), .cursor_y_o(cursor_y), .busy_o(busy), .cursor_hit_o(cursor_hit)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    ram_rd_q <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = force_rd ? 8'h5A : ram_rd_q;

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_auto) begin
        ph = (ph + 1) % 4;
        p_tick = (ph == 0);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // every DUT write must match the head of the expected queue and never coincide with p_tick
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      logic [20:0] e;
      logic        have;
      wr_cnt++;
      have = (exp_q.size() > 0);
      e = have ? {1'b0, exp_q.pop_front()} : 21'h1FFFFF;
      n_total++;
      assert (have && ({p_tick, mem_addr, mem_wdata} === e)) n_pass++;
      else begin
        n_fail++;
        $error("FAIL write: got tick=%0d addr=%0d data=%0h expected addr=%0d data=%0h (queued=%0d)",
               p_tick, mem_addr, mem_wdata, e[19:8], e[7:0], have);
      end
    end
  end

  task automatic push(input int addr, input logic [7:0] d);
    exp_q.push_back({12'(addr), d});
  endtask

  task automatic push_row(input int r);
    for (int c = 0; c < 80; c++) push(r * 80 + c, 8'h20);
  endtask

  task automatic push_all();
    for (int a = 0; a < 2400; a++) push(a, 8'h20);
  endtask

  task automatic model_key(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push(cy * 80 + cx, b);
      if (cx < 79) cx++;
      else begin
        cx = 0;
        cy = (cy == 29) ? 0 : cy + 1;
        push_row(cy);
      end
    end else if (b == 8'h0D) begin
      cx = 0;
      cy = (cy == 29) ? 0 : cy + 1;
      push_row(cy);
    end else if (b == 8'h08) begin
      if (cx > 0) begin cx--; push(cy * 80 + cx, 8'h20); end
      else if (cy > 0) begin cx = 79; cy--; push(cy * 80 + cx, 8'h20); end
    end else if (b == 8'h1B) begin
      cx = 0; cy = 0;
      push_all();
    end
  endtask

  task automatic send(input logic [7:0] b);
    int cyc;
    cyc = 0;
    @(posedge clk); #1;
    key_valid = 1'b1;
    key_ascii = b;
    @(negedge clk);
    while (!key_ready && cyc < 5000) begin @(negedge clk); cyc++; end
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && cyc < 20000) begin @(negedge clk); cyc++; end
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic key(input logic [7:0] b, input string tag);
    model_key(b);
    send(b);
    wait_idle(tag);
    chk({tag, "_cx"}, 32'(cursor_x), 32'(cx));
    chk({tag, "_cy"}, 32'(cursor_y), 32'(cy));
    chk({tag, "_ready"}, 32'(key_ready), 32'd1);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; p_tick = 1'b0; data_ena = 1'b0; x_pos = 10'd0; y_pos = 10'd0;
    key_valid = 1'b0; key_ascii = 8'h00; tick_auto = 1'b1; force_rd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_cx", 32'(cursor_x), 32'd0);
    chk("rst_cy", 32'(cursor_y), 32'd0);
    chk("rst_ready", 32'(key_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_disp", 32'(disp_char), 32'd0);
    chk("rst_hit", 32'(cursor_hit), 32'd0);
    push_all();
    rst = 1'b0;
    wait_idle("init");
    chk("init_ready", 32'(key_ready), 32'd1);
    chk("init_wrcnt", 32'(wr_cnt), 32'd2400);
    chk("init_cx", 32'(cursor_x), 32'd0);

    key(8'h41, "char_A");
    for (int i = 0; i < 78; i++) begin
      model_key(8'h61 + 8'(i % 26));
      send(8'h61 + 8'(i % 26));
      wait_idle("fill");
    end
    chk("fill_cx", 32'(cursor_x), 32'd79);
    key(8'h42, "eol_wrap");
    key(8'h08, "bs_row");
    key(8'h1B, "esc1");
    key(8'h08, "bs_origin");
    for (int i = 0; i < 29; i++) begin
      model_key(8'h0D);
      send(8'h0D);
      wait_idle("enter_n");
    end
    for (int i = 0; i < 5; i++) key(8'h30 + 8'(i), "row29");
    key(8'h0D, "enter_wrap");
    key(8'h01, "ctrl_ignored");

    // ESC, then reset in the middle of the full clear
    model_key(8'h1B);
    send(8'h1B);
    cyc = wr_cnt;
    while (wr_cnt < cyc + 100 && cyc > -1) begin
      @(negedge clk);
      if (wr_cnt == cyc && busy == 1'b0) break;
    end
    chk("esc_busy_mid", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    chk("rst2_busy", 32'(busy), 32'd1);
    chk("rst2_ready", 32'(key_ready), 32'd0);
    chk("rst2_cx", 32'(cursor_x), 32'd0);
    cx = 0; cy = 0;
    push_all();
    rst = 1'b0;

    // display read wins the port while the clear is pending
    @(negedge clk);
    tick_auto = 1'b0;
    @(posedge clk); #1;
    p_tick = 1'b1; data_ena = 1'b1; x_pos = 10'd17; y_pos = 10'd35;
    @(negedge clk);
    chk("arb_addr", 32'(mem_addr), 32'd162);
    chk("arb_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    p_tick = 1'b0; data_ena = 1'b0; x_pos = 10'd0; y_pos = 10'd0; force_rd = 1'b1;
    @(posedge clk); #1;
    force_rd = 1'b0;
    chk("disp_char", 32'(disp_char), 32'h5A);
    tick_auto = 1'b1;
    wait_idle("reclear");
    chk("reclear_cx", 32'(cursor_x), 32'd0);
    chk("reclear_cy", 32'(cursor_y), 32'd0);
    chk("reclear_ready", 32'(key_ready), 32'd1);
    key(8'h5A, "post_char");
    repeat (20) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
